sram_ctrl: RTL
==============

SRAM_CTRL -- requirements
Module: sram_ctrl

Interface
REQ-001 Parameter DATA_W, default 16, word width in bits; SHALL be a multiple of 8.
REQ-002 Parameter ADDR_W, default 8, address width; depth DEPTH = 2**ADDR_W words.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 valid  input  1  request valid.
REQ-006 ready  output  1  request accepted when valid && ready at a rising edge.
REQ-007 wr_rd  input  1  1 = write, 0 = read.
REQ-008 addr  input  ADDR_W  word address.
REQ-009 wr_data  input  DATA_W  write data.
REQ-010 wr_strb  input  DATA_W/8  byte write enables; present only with SRAM_CTRL_BYTE_EN.
REQ-011 clr  input  1  synchronous request to re-zero the whole array.
REQ-012 rd_data  output  DATA_W  read response data.
REQ-013 rd_valid  output  1  read response valid.
REQ-014 rd_ready  input  1  response consumed when rd_valid && rd_ready.
REQ-015 init_done  output  1  high while the array is cleared and in service.

Function
REQ-016 FSM states CLEAR and RUN; CLEAR writes zero to address cnt each cycle, cnt 0..DEPTH-1.
REQ-017 CLEAR -> RUN on the cycle cnt == DEPTH-1 is written; cnt returns to 0; init_done rises with RUN.
REQ-018 RUN -> CLEAR on clr == 1; init_done falls the next cycle; clr in CLEAR is ignored, cnt not restarted.
REQ-019 ready = (state == RUN) && !clr && (!rd_valid || rd_ready); combinational, no request accepted in CLEAR.
REQ-020 Accepted write updates mem[addr] at that edge; no response generated.
REQ-021 Accepted read: rd_data = mem[addr], rd_valid = 1 on the next edge (latency 1).
REQ-022 rd_data and rd_valid SHALL hold stable while rd_valid && !rd_ready.
REQ-023 rd_valid clears on handshake unless a new read is accepted in the same cycle (back-to-back, one read per cycle).
REQ-024 Read after write to the same address in the following cycle SHALL return the new data.
REQ-025 A pending response survives RUN -> CLEAR and drains normally.
REQ-026 Address is used modulo DEPTH; no out-of-range case exists.

Reset
REQ-027 rst low: state = CLEAR, cnt = 0, rd_valid = 0, rd_data = 0, init_done = 0, ready = 0, immediately and asynchronously.
REQ-028 Array contents are not reset directly; zeroing completes DEPTH cycles after rst deasserts.
REQ-029 Reset mid-read drops the pending response; reset mid-clear restarts at cnt = 0.

Configuration
REQ-030 Macro SRAM_CTRL_BYTE_EN defined: wr_strb present; byte i of mem[addr] written only if wr_strb[i] == 1.
REQ-031 Macro undefined: no wr_strb port; every accepted write replaces the full word.

Structure
REQ-032 Package sram_ctrl_pkg holds the state enum (CLEAR, RUN) and the DATA_W/ADDR_W defaults.
REQ-033 Storage is sub-module sram_ctrl_array: one write port with byte enables and one synchronous read port, no reset.

Verification
REQ-034 Release rst, hold valid = 1 -> ready = 0 for 256 cycles, init_done = 1 and ready = 1 on cycle 257; read 0x00, 0xFF -> 0x0000 each.
REQ-035 Write 0x12 = 0xBEEF, next cycle read 0x12 -> rd_data = 0xBEEF, rd_valid = 1 exactly one cycle after acceptance.
REQ-036 Read 0x12 with rd_ready = 0 for 5 cycles -> rd_data = 0xBEEF stable, ready = 0, until rd_ready = 1.
REQ-037 Byte enables on: write 0x12 = 0x5566 with wr_strb = 2'b01 -> read returns 0xBE66; macro off: returns 0x5566.
REQ-038 clr pulse after writing 0x34 = 0xA5A5 -> init_done = 0, 256 clear cycles, then read 0x34 -> 0x0000.
REQ-039 rst low during a pending read -> rd_valid = 0 at once; after re-clear, all reads return 0x0000.

Source files
------------

// File: rtl/sram_ctrl_pkg.sv
// Shared types and default geometry for the SRAM controller.
// Build option: SRAM_CTRL_BYTE_EN adds per-byte write strobes.
package sram_ctrl_pkg;

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_e;

    localparam int DATA_W_DEF = 16;
    localparam int ADDR_W_DEF = 8;

endpackage

// File: rtl/sram_ctrl_array.sv
// Storage array: one byte-enabled write port and one registered read port.
// Contents have no reset; the controller zeroes them by sweeping addresses.
module sram_ctrl_array
    import sram_ctrl_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic                clk,
    input  logic                we_i,
    input  logic [ADDR_W-1:0]   waddr_i,
    input  logic [DATA_W-1:0]   wdata_i,
    input  logic [DATA_W/8-1:0] wstrb_i,
    input  logic                re_i,
    input  logic [ADDR_W-1:0]   raddr_i,
    output logic [DATA_W-1:0]   rdata_o
);

    localparam int NB = DATA_W / 8;

    logic [DATA_W-1:0] mem_q [2**ADDR_W];
    logic [DATA_W-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we_i) begin
            for (int i = 0; i < NB; i++) begin
                if (wstrb_i[i]) begin
                    mem_q[waddr_i][8*i +: 8] <= wdata_i[8*i +: 8];
                end
            end
        end
        if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/sram_ctrl.sv
// SRAM controller: zeroes the array after reset or clr, then serves requests.
// Build option: SRAM_CTRL_BYTE_EN adds the wr_strb byte-enable port.
module sram_ctrl
    import sram_ctrl_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                valid,
    output logic                ready,
    input  logic                wr_rd,
    input  logic [ADDR_W-1:0]   addr,
    input  logic [DATA_W-1:0]   wr_data,
`ifdef SRAM_CTRL_BYTE_EN
    input  logic [DATA_W/8-1:0] wr_strb,
`endif
    input  logic                clr,
    output logic [DATA_W-1:0]   rd_data,
    output logic                rd_valid,
    input  logic                rd_ready,
    output logic                init_done
);

    localparam int NB    = DATA_W / 8;
    localparam int DEPTH = 2**ADDR_W;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   cnt_q, cnt_d;
    logic                rd_valid_q, rd_valid_d;
    logic                acc, rd_acc, wr_acc, clearing;
    logic                we;
    logic [ADDR_W-1:0]   waddr;
    logic [DATA_W-1:0]   wdata;
    logic [NB-1:0]       wstrb, strb_req;
    logic [DATA_W-1:0]   arr_rdata;

`ifdef SRAM_CTRL_BYTE_EN
    assign strb_req = wr_strb;
`else
    assign strb_req = '1;
`endif

    assign clearing = (state_q == CLEAR);
    assign ready    = !clearing && !clr && (!rd_valid_q || rd_ready);
    assign acc      = valid && ready;
    assign rd_acc   = acc && !wr_rd;
    assign wr_acc   = acc && wr_rd;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= CLEAR;
            cnt_q      <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        rd_valid_d = rd_valid_q;
        unique case (state_q)
            CLEAR: begin
                // cnt wraps back to 0 on the final clear write
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == ADDR_W'(DEPTH - 1)) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (clr) begin
                    state_d = CLEAR;
                end
            end
            default: state_d = CLEAR;
        endcase
        if (rd_acc) begin
            rd_valid_d = 1'b1;
        end else if (rd_valid_q && rd_ready) begin
            rd_valid_d = 1'b0;
        end
    end

    // Clear sweep owns the write port; reads are never accepted meanwhile.
    always_comb begin
        we    = wr_acc;
        waddr = addr;
        wdata = wr_data;
        wstrb = strb_req;
        if (clearing) begin
            we    = 1'b1;
            waddr = cnt_q;
            wdata = '0;
            wstrb = '1;
        end
    end

    sram_ctrl_array #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_array (
        .clk     (clk),
        .we_i    (we),
        .waddr_i (waddr),
        .wdata_i (wdata),
        .wstrb_i (wstrb),
        .re_i    (rd_acc),
        .raddr_i (addr),
        .rdata_o (arr_rdata)
    );

    assign rd_valid  = rd_valid_q;
    assign rd_data   = rd_valid_q ? arr_rdata : '0;
    assign init_done = !clearing;

endmodule
